// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle.
// master: the scanner (drives rows and key outputs, senses columns).
// slave:  the keypad/consumer side (drives columns, observes everything else).
interface keypad_scanner_if;
    logic [3:0] o_row;
    logic [3:0] i_col;
    logic       o_key_valid;
    logic [3:0] o_key_code;
    logic       o_is_digit;
    logic [3:0] o_digit_val;
    logic [2:0] o_op_code;
    logic       o_key_held;

    modport master (
        output o_row,
        input  i_col,
        output o_key_valid,
        output o_key_code,
        output o_is_digit,
        output o_digit_val,
        output o_op_code,
        output o_key_held
    );

    modport slave (
        input  o_row,
        output i_col,
        input  o_key_valid,
        input  o_key_code,
        input  o_is_digit,
        input  o_digit_val,
        input  o_op_code,
        input  o_key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-based press/release debounce.
// Rows are strobed active-low one at a time; columns are sampled on the last
// cycle of each row period and four row periods form one frame. A frame with
// exactly one low key yields that key, anything else yields "none".
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-pulse o_key_valid every
// REPEAT_FRAMES frames while a key stays held.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 100000,
    parameter int unsigned DEBOUNCE_FRAMES = 8,
    parameter int unsigned REPEAT_FRAMES   = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  bus
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] DbCount = CntW'(DEBOUNCE_FRAMES);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StPressDb   = 2'd1;
    localparam logic [1:0] StHeld      = 2'd2;
    localparam logic [1:0] StReleaseDb = 2'd3;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RepW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES + 1) : 1;
    localparam logic [RepW-1:0] RepCount = RepW'(REPEAT_FRAMES);
`endif

    // Key code at (row, col), col0 = bit 0.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        unique case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            4'hF: k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    // ---------------------------------------------------------------------
    // Column synchronizer
    // ---------------------------------------------------------------------
    logic [3:0] col_meta_q, col_meta_d;
    logic [3:0] col_sync_q, col_sync_d;

    // Two-flop synchronizer input stage for the asynchronous column lines.
    always_comb begin
        col_meta_d = bus.i_col;
        col_sync_d = col_meta_q;
    end

    // Synchronizer flops idle high (no key pressed).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= col_meta_d;
            col_sync_q <= col_sync_d;
        end
    end

    // ---------------------------------------------------------------------
    // Row strobe divider
    // ---------------------------------------------------------------------
    logic [DivW-1:0] div_q, div_d;
    logic [3:0]      row_q, row_d;
    logic            sample;
    logic [1:0]      row_idx;

    // Divider wrap marks the sampling cycle and advances the active row.
    always_comb begin
        sample = (div_q == DivLast);
        div_d  = sample ? '0 : div_q + 1'b1;
        row_d  = sample ? {row_q[2:0], row_q[3]} : row_q;
    end

    // Row index of the single low row bit.
    always_comb begin
        row_idx = 2'd0;
        unique case (row_q)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    // Divider and row register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            row_q <= 4'b1110;
        end else begin
            div_q <= div_d;
            row_q <= row_d;
        end
    end

    // ---------------------------------------------------------------------
    // Frame accumulation
    // ---------------------------------------------------------------------
    logic [3:0] col_low;
    logic [1:0] row_hits;     // 0, 1, or 2 meaning "two or more"
    logic [1:0] col_idx;
    logic [1:0] base_hits;
    logic [3:0] base_code;
    logic [2:0] hit_sum;
    logic [1:0] frame_hits;
    logic [3:0] frame_code;
    logic       frame_end;
    logic       frame_key;
    logic [1:0] acc_hits_q, acc_hits_d;
    logic [3:0] acc_code_q, acc_code_d;

    // Count low columns in the sampled row and remember the first one.
    always_comb begin
        col_low  = ~col_sync_q;
        row_hits = 2'd0;
        col_idx  = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (col_low[c]) begin
                if (row_hits == 2'd0) begin
                    col_idx = 2'(c);
                end
                row_hits = (row_hits == 2'd0) ? 2'd1 : 2'd2;
            end
        end
    end

    // Fold this row into the running frame result; row 0 starts a fresh frame.
    always_comb begin
        base_hits  = (row_idx == 2'd0) ? 2'd0 : acc_hits_q;
        base_code  = (row_idx == 2'd0) ? 4'h0 : acc_code_q;
        hit_sum    = {1'b0, base_hits} + {1'b0, row_hits};
        frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_code = (row_hits == 2'd1) ? key_map(row_idx, col_idx) : base_code;
        acc_hits_d = sample ? frame_hits : acc_hits_q;
        acc_code_d = sample ? frame_code : acc_code_q;
        frame_end  = sample && (row_idx == 2'd3);
        frame_key  = (frame_hits == 2'd1);
    end

    // Frame accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hits_q <= 2'd0;
            acc_code_q <= 4'h0;
        end else begin
            acc_hits_q <= acc_hits_d;
            acc_code_q <= acc_code_d;
        end
    end

    // ---------------------------------------------------------------------
    // Debounce FSM
    // ---------------------------------------------------------------------
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            match;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [RepW-1:0] rep_q, rep_d;
    logic [RepW-1:0] rep_inc;
`endif

    // Next-state logic; transitions only happen on the frame-end sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = 1'b0;
        cnt_inc = cnt_q + 1'b1;
        match   = frame_key && (frame_code == cand_q);
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = rep_q;
        rep_inc = rep_q + 1'b1;
`endif
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_key) begin
                        cand_d  = frame_code;
                        cnt_d   = CntOne;
                        state_d = StPressDb;
                        if (DbCount == CntOne) begin
                            state_d = StHeld;
                            cnt_d   = '0;
                            code_d  = frame_code;
                            valid_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end
                end
                StPressDb: begin
                    if (match) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DbCount) begin
                            state_d = StHeld;
                            cnt_d   = '0;
                            code_d  = cand_q;
                            valid_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        // A different key or a gap aborts; that frame is not reused.
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StHeld: begin
                    if (!match) begin
                        state_d = StReleaseDb;
                        cnt_d   = CntOne;
                        if (DbCount == CntOne) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_inc == RepCount) begin
                        rep_d   = '0;
                        valid_d = 1'b1;
                    end else begin
                        rep_d = rep_inc;
                    end
`endif
                end
                StReleaseDb: begin
                    // Repeat counter deliberately untouched here (paused).
                    if (match) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DbCount) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state, debounce counter, candidate and accepted-key registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cand_q  <= 4'h0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Output decode
    // ---------------------------------------------------------------------
    logic       is_digit;
    logic [3:0] digit_val;
    logic [2:0] op_code;

    // Decode the held code into digit / operator views.
    always_comb begin
        is_digit  = (code_q <= 4'd9);
        digit_val = is_digit ? code_q : 4'hF;
        case (code_q)
            4'hA:    op_code = 3'b001;
            4'hB:    op_code = 3'b011;
            4'hC:    op_code = 3'b010;
            4'hD:    op_code = 3'b000;
            default: op_code = 3'b111;
        endcase
    end

    assign bus.o_row       = row_q;
    assign bus.o_key_valid = valid_q;
    assign bus.o_key_code  = code_q;
    assign bus.o_is_digit  = is_digit;
    assign bus.o_digit_val = digit_val;
    assign bus.o_op_code   = op_code;
    assign bus.o_key_held  = (state_q == StHeld) || (state_q == StReleaseDb);

endmodule
